// File: rtl/muldiv_unit_if.sv
// Bus between the control path and the HI/LO multiply/divide unit.
// The abort signal exists only when MULDIV_ABORT_EN is defined.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
  logic             abort;

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, abort,
    output busy, done, div_by_zero, hi, lo
  );
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, abort,
    input  busy, done, div_by_zero, hi, lo
  );
`else
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per clock, WIDTH iterations.
// Optional MULDIV_ABORT_EN adds an abort input that squashes an in-flight operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZ} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_isdiv, r_neg_res, r_neg_rem;
  logic                 r_done, r_dz;

  logic                 w_abort, w_launch, w_last, w_div_op, w_b_zero;
  logic                 w_sgn_a, w_sgn_b;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [WIDTH:0]       w_msum, w_rsh, w_rdiff;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem, w_res_hi, w_res_lo;

`ifdef MULDIV_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // A start that coincides with abort never launches.
  assign w_launch = (r_state == S_IDLE) && bus.start && !w_abort;
  assign w_last   = (r_cnt == LAST);
  assign w_div_op = bus.op[1];
  assign w_b_zero = (bus.b == '0);

  // op[0]=0 selects the signed flavour; magnitudes feed an unsigned core.
  assign w_sgn_a  = !bus.op[0] && bus.a[WIDTH-1];
  assign w_sgn_b  = !bus.op[0] && bus.b[WIDTH-1];
  assign w_mag_a  = w_sgn_a ? (~bus.a + 1'b1) : bus.a;
  assign w_mag_b  = w_sgn_b ? (~bus.b + 1'b1) : bus.b;

  // Shift-add step: low half holds the unconsumed multiplier bits.
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring step: high half is the partial remainder, low half shifts quotient bits in.
  assign w_rsh     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rdiff   = w_rsh - {1'b0, r_opnd};
  assign w_qbit    = !w_rdiff[WIDTH];
  assign w_div_nxt = {(w_qbit ? w_rdiff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_qbit};

  assign w_acc_nxt = r_isdiv ? w_div_nxt : w_mul_nxt;

  // Sign correction applies to the value produced by the final iteration.
  assign w_prod   = r_neg_res ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quo    = r_neg_res ? (~w_acc_nxt[WIDTH-1:0] + 1'b1) : w_acc_nxt[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? (~w_acc_nxt[2*WIDTH-1:WIDTH] + 1'b1)
                              : w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_res_hi = r_isdiv ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_isdiv ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = (w_div_op && w_b_zero) ? S_DZ : S_RUN;
      end
      S_RUN: begin
        if (w_abort || w_last) w_state_nxt = S_IDLE;
      end
      S_DZ:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isdiv   <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_isdiv   <= w_div_op;
            r_neg_res <= w_sgn_a ^ w_sgn_b;
            r_neg_rem <= w_sgn_a;
            r_opnd    <= w_div_op ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (w_div_op ? w_mag_a : w_mag_b)};
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_RUN: begin
          if (!w_abort) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi   <= w_res_hi;
              r_lo   <= w_res_lo;
              r_done <= 1'b1;
            end
          end
        end
        S_DZ: begin
          if (!w_abort) begin
            r_done <= 1'b1;
            r_dz   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, signed/unsigned results,
// divide-by-zero, ignored start/writes while busy, back-to-back and reset/abort.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy, output logic dz_launch);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dz_launch = bus.div_by_zero;
    lat = 1; nbusy = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
  endtask

  task automatic test_multu();
    int lat, nb; logic dz;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, dz);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL multu_latency got %0d want 33", lat); end
    n_cmp++; if (nb !== 32) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want 32", nb); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle got %b want 0", bus.done); end
  endtask

  task automatic test_mult();
    int lat, nb; logic dz;
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, nb, dz);
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", bus.hi); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_neg_lo got %h want ffffffeb", bus.lo); end
    tick();
    run_op(2'b00, 32'h80000000, 32'h80000000, lat, nb, dz);
    n_cmp++; if (bus.hi !== 32'h40000000) begin n_bad++; $display("FAIL mult_min_hi got %h want 40000000", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL mult_min_lo got %h want 0", bus.lo); end
    tick();
  endtask

  task automatic test_div();
    int lat, nb; logic dz;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, nb, dz);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency got %0d want 33", lat); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); end
    tick();
    run_op(2'b11, 32'd7, 32'd2, lat, nb, dz);
    n_cmp++; if (bus.lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got %h want 3", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got %h want 1", bus.hi); end
    tick();
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, nb, dz);
    n_cmp++; if (bus.lo !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi got %h want 0", bus.hi); end
    tick();
  endtask

  task automatic test_div_by_zero();
    int lat, nb; logic dz;
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    tick();
    bus.lo_we = 1'b0;
    n_cmp++; if (bus.hi !== 32'h11) begin n_bad++; $display("FAIL mthi got %h want 11", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h22) begin n_bad++; $display("FAIL mtlo got %h want 22", bus.lo); end
    run_op(2'b10, 32'd5, 32'd0, lat, nb, dz);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dz_latency got %0d want 2", lat); end
    n_cmp++; if (bus.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", bus.div_by_zero); end
    n_cmp++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin n_bad++; $display("FAIL dz_hilo got %h/%h want 11/22", bus.hi, bus.lo); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_hold got busy %b dz %b want 0 1", bus.busy, bus.div_by_zero); end
    run_op(2'b11, 32'd9, 32'd3, lat, nb, dz);
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL dz_clear got %b want 0", dz); end
    n_cmp++; if (bus.lo !== 32'd3 || bus.hi !== 32'd0) begin n_bad++; $display("FAIL divu_9_3 got %h/%h want 0/3", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    bus.op = 2'b01; bus.a = 32'h12345678; bus.b = 32'h10; bus.start = 1'b1;
    tick();
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'hAA;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ignore_latency got %0d want 33", lat); end
    n_cmp++; if (bus.hi !== 32'h1 || bus.lo !== 32'h23456780) begin n_bad++; $display("FAIL ignore_result got %h/%h want 00000001/23456780", bus.hi, bus.lo); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue got busy %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic dz;
    run_op(2'b01, 32'd3, 32'd5, lat, nb, dz);
    n_cmp++; if (bus.lo !== 32'd15) begin n_bad++; $display("FAIL b2b_first got %h want f", bus.lo); end
    run_op(2'b11, 32'd100, 32'd7, lat, nb, dz);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency got %0d want 33", lat); end
    n_cmp++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_bad++; $display("FAIL b2b_second got %h/%h want 2/e", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_reset_mid();
    int ndone;
    bus.op = 2'b01; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL midreset_ctl got busy %b done %b want 0 0", bus.busy, bus.done); end
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_bad++; $display("FAIL midreset_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.done === 1'b1) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL midreset_no_done got %0d pulses want 0", ndone); end
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort();
    int ndone;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h33;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'b01; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_ctl got busy %b done %b want 0 0", bus.busy, bus.done); end
    n_cmp++; if (bus.hi !== 32'h33 || bus.lo !== 32'h33) begin n_bad++; $display("FAIL abort_hilo got %h/%h want 33/33", bus.hi, bus.lo); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.done === 1'b1) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_suppress_start got busy %b want 0", bus.busy); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It complements the single-cycle ALU, which has no multiply or divide opcodes. It receives the same rs/rt operand buses the ALU receives. It handshakes with the control path through start/busy/done so the pipeline can stall on MFHI/MFLO while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch an operation; sampled only while busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO have just been updated
div_by_zero  output  1  last DIV/DIVU had b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0; state=IDLE, iteration counter=0. Reset overrides every other input, including mid-operation; any partial result is discarded.
- States:
  - IDLE: start=1 moves the FSM to RUN, or to DZ when the op is DIV/DIVU and b=0.
  - RUN: lasts exactly WIDTH edges, then returns to IDLE.
  - DZ: lasts one edge, then returns to IDLE.
- Launch: on the edge that samples start, latch |a|, |b|, op, and the result-sign flags.
  - Signed ops take magnitudes (two's complement when the MSB is set).
  - Unsigned ops take the operands as-is.
  - busy=1 from that edge, and div_by_zero clears.
- Multiply: shift-add, one multiplier bit per edge, into a 2*WIDTH accumulator.
- Divide: restoring division, one quotient bit per edge.
- Timing: with start sampled at edge N, busy=1 after edges N..N+WIDTH-1.
  - At edge N+WIDTH, the sign-corrected result is written to HI/LO, busy=0, done=1 for exactly one cycle.
  - Total latency is WIDTH+1 cycles from the start cycle to done.
- Result placement:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0]. A signed product is negated when the operand signs differ.
  - Divide: lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap is raised.
- Divide by zero: the FSM takes the DZ path with no iteration.
  - At the next edge: done=1, div_by_zero=1, hi/lo unchanged, busy=0 after that edge.
  - div_by_zero holds until the next accepted start or reset.
- start while busy=1 is ignored (no queueing). The control path must stall.
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the edge, only in IDLE.
  - Both strobes together write both registers.
  - Strobes are ignored while busy.
  - start and a write strobe in the same IDLE cycle: start wins and the write is dropped.
- hi/lo are directly readable at all times. While busy they hold their previous values; intermediate results are never exposed.
- done and start may coincide: a new op is accepted in the done cycle, since busy=0 then.

Optional Feature:
MULDIV_ABORT_EN
- Defined: adds an input port abort (1 bit).
  - abort=1 in RUN or DZ returns the FSM to IDLE at that edge: busy=0, no done pulse, hi/lo and div_by_zero unchanged.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: start is suppressed.
  - Used by the exception logic to squash a faulting instruction's multiply/divide.
- Undefined: no abort port; every accepted operation runs to completion.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles; done in cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x11, MTLO 0x22, then DIV a=5 b=0 -> done one cycle after start, div_by_zero=1, hi=0x11, lo=0x22. Next DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
- During a MULTU, pulse start with op=DIVU and hi_we=1 wdata=0xAA at cycle 5 -> both ignored; original product is written. Back-to-back start in the done cycle -> accepted.
- reset at cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows. With MULDIV_ABORT_EN defined: abort at cycle 10 -> busy=0, hi/lo hold their pre-start values.
